uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter OVS, default 16: oversample ticks per bit; power of two, at least 4.
REQ-002 Parameter FIFO_DEPTH, default 4: receive FIFO entries; power of two.
REQ-003 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port io_i_en, input, 1: receiver enable.
REQ-006 Port io_i_div, input, 16: tick period minus 1, in clock cycles.
REQ-007 Port io_i_rx, input, 1: asynchronous serial line; idles high; 8N1 format, LSB first.
REQ-008 Port io_o_valid, output, 1: FIFO head holds a byte.
REQ-009 Port io_o_data, output, 8: FIFO head byte.
REQ-010 Port io_i_ready, input, 1: consumer accepts the head byte.
REQ-011 Port io_o_ferr, output, 1: sticky framing-error flag.
REQ-012 Port io_o_ovf, output, 1: sticky overflow flag.
REQ-013 Port io_i_clr, input, 1: clears both sticky flags.

Function
REQ-014 io_i_rx shall pass through a 2-flop synchronizer before any other logic uses it; both flops reset to 1.
REQ-015 Tick counter: counts 0..io_i_div, then wraps to 0 and pulses tick for one cycle; io_i_div=0 gives a tick every cycle.
REQ-016 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-017 In IDLE, the tick counter and the sample counter shall be held at 0.
REQ-018 IDLE->START when the synchronized line is 0.
REQ-019 START: sample the line on tick number OVS/2. If the sample is 1, go to IDLE (glitch rejected). If 0, go to DATA and clear the sample counter.
REQ-020 DATA: sample one bit every OVS ticks into a shift register, LSB first; after the 8th bit, go to STOP.
REQ-021 STOP: sample after OVS ticks. If 1, push the byte and go to IDLE. If 0, set io_o_ferr, discard the byte and go to WAIT_IDLE.
REQ-022 WAIT_IDLE->IDLE when the synchronized line is 1.
REQ-023 io_i_en=0 shall force the FSM to IDLE on the next cycle, including mid-frame, and discard any partial byte; FIFO contents and draining are unaffected.
REQ-024 FIFO: the pop handshake is io_o_valid && io_i_ready. io_o_valid = !empty; io_o_data = head, and is held stable while valid && !ready.
REQ-025 Push latency: io_o_valid shall assert the cycle after the stop-bit sample cycle when the FIFO was empty.
REQ-026 Push when full and no pop in the same cycle: drop the byte, set io_o_ovf, and leave the contents unchanged.
REQ-027 Push and pop in the same cycle when full: both shall occur and io_o_ovf shall not be set.
REQ-028 Push and pop in the same cycle when empty: only the push occurs.
REQ-029 Read and write pointers shall carry log2(FIFO_DEPTH)+1 bits and wrap naturally.
REQ-030 io_i_clr clears the sticky flags; a set event in the same cycle takes priority.

Reset
REQ-031 Reset shall place the FSM in IDLE, clear the tick counter, sample counter, bit counter and shift register, and empty the FIFO.
REQ-032 Output values in reset: io_o_valid=0, io_o_data=0x00, io_o_ferr=0, io_o_ovf=0.
REQ-033 Reset mid-frame shall discard the partial byte; reset has priority over all other inputs.

Structure
REQ-034 Shared package uart_pkg: FSM state enum, OVS default, FIFO_DEPTH default, frame data width (8).
REQ-035 The FIFO shall be a separate sub-module, uart_rx_fifo, with parameterized depth and width and push/pop/full/empty ports.

Verification
REQ-036 div=0, send 0xA5 (16 cycles/bit), ready=1 -> exactly one valid pulse with data 0xA5; ferr=0, ovf=0.
REQ-037 Line driven low for 4 cycles, then high -> FSM returns to IDLE; no valid, no ferr.
REQ-038 Frame 0x5A with stop bit 0, then line held low for 40 cycles before going high -> ferr=1, no valid, FSM in WAIT_IDLE until the line goes high; then 0x11 is received correctly.
REQ-039 ready=0, send 0x01..0x05 -> ovf=1 after the 5th frame; draining yields 0x01, 0x02, 0x03, 0x04, then valid=0.
REQ-040 div=2 (48 cycles/bit), drop en during bit 3 of 0xC3, raise en, send 0x3C -> only 0x3C is delivered.
REQ-041 FIFO full with ready=1 asserted exactly on the stop-sample cycle -> ovf=0 and the new byte is at the tail.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and default sizing.
package uart_pkg;

  localparam int unsigned OVS_DEFAULT        = 16;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
  localparam int unsigned DATA_W             = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: power-of-two depth, extra pointer bit distinguishes full from empty.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_c,
  output logic             empty_c,
  output logic [WIDTH-1:0] head_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign do_pop  = pop_i && !empty_c;
  assign do_push = push_i && (!full_c || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: synchronizer, oversampling tick, frame FSM, receive FIFO, sticky flags.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned OVS        = OVS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_i_en,
  input  logic [15:0] io_i_div,
  input  logic        io_i_rx,
  output logic        io_o_valid,
  output logic [7:0]  io_o_data,
  input  logic        io_i_ready,
  output logic        io_o_ferr,
  output logic        io_o_ovf,
  input  logic        io_i_clr
);

  localparam int unsigned SW = $clog2(OVS);
  localparam int unsigned BW = $clog2(DATA_W);

  rx_state_e         state_q, state_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_sync_q, rx_sync_d;
  logic [15:0]       tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]     samp_cnt_q, samp_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;

  logic              tick;
  logic              push;
  logic              pop;
  logic              ferr_set;
  logic              ovf_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign tick      = (tick_cnt_q == io_i_div);
  assign rx_meta_d = io_i_rx;
  assign rx_sync_d = rx_meta_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 16'(1);
    samp_cnt_d = tick ? samp_cnt_q + SW'(1) : samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push       = 1'b0;
    ferr_set   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        samp_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_sync_q) state_d = START;
      end
      // Mid-start-bit check rejects glitches shorter than half a bit.
      START: begin
        if (tick && samp_cnt_q == SW'(OVS / 2 - 1)) begin
          samp_cnt_d = '0;
          state_d    = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && samp_cnt_q == SW'(OVS - 1)) begin
          shift_d   = {rx_sync_q, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_W - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && samp_cnt_q == SW'(OVS - 1)) begin
          if (rx_sync_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Disabling abandons the frame in progress without touching the FIFO.
    if (!io_i_en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      push      = 1'b0;
      ferr_set  = 1'b0;
    end
  end

  assign pop     = !fifo_empty && io_i_ready;
  assign ovf_set = push && fifo_full && !pop;

  always_comb begin
    ferr_d = ferr_q;
    ovf_d  = ovf_q;
    if (io_i_clr) begin
      ferr_d = 1'b0;
      ovf_d  = 1'b0;
    end
    if (ferr_set) ferr_d = 1'b1;
    if (ovf_set)  ovf_d  = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .full_c      (fifo_full),
    .empty_c     (fifo_empty),
    .head_c      (fifo_head)
  );

  assign io_o_valid = !fifo_empty;
  assign io_o_data  = fifo_head;
  assign io_o_ferr  = ferr_q;
  assign io_o_ovf   = ovf_q;

endmodule
